// File: rtl/rst_req_pkg.sv
// Shared state encoding and sizing helpers for the reset-request generator.
package rst_req_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ASSERT     = 3'd1;
    localparam logic [2:0] ST_WAIT_LO    = 3'd2;
    localparam logic [2:0] ST_RELEASE_HI = 3'd3;
    localparam logic [2:0] ST_COOL       = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_ASSERT     = ST_ASSERT,
        S_WAIT_LO    = ST_WAIT_LO,
        S_RELEASE_HI = ST_RELEASE_HI,
        S_COOL       = ST_COOL
    } state_t;

    function automatic int tcnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchronizer with a configurable reset value.
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {N{RST_VAL}};
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/rst_req_gen.sv
// Drives a programmable-width reset pulse downstream and confirms
// entry/exit through the synchronized feedback of the far-side synchronizer.
module rst_req_gen
    import rst_req_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MIN_PULSE = 4,
    parameter int FB_STAGES = 2,
    parameter int TIMEOUT   = 255,
    parameter int COOLDOWN  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic             rst_fb,
    output logic             rst_n_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TW = tcnt_width(TIMEOUT);
    localparam int MIN_P = (MIN_PULSE < 1) ? 1 : MIN_PULSE;
    localparam int COOL_P = (COOLDOWN < 1) ? 1 : COOLDOWN;
    localparam int TO_P = (TIMEOUT < 1) ? 1 : TIMEOUT;

    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_P);
    localparam logic [CNT_W-1:0] COOL_V = CNT_W'(COOL_P);
    localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);
    localparam logic [TW-1:0]    TO_LST = TW'(TO_P - 1);
    localparam logic [TW-1:0]    TO_MAX = TW'(TO_P);

    state_t           state, state_nx;
    logic [CNT_W-1:0] pcnt, pcnt_nx;
    logic [TW-1:0]    tcnt, tcnt_nx, tcnt_inc;
    logic             err_nx, done_nx, t_hit, fb_s;

    bit_sync #(
        .STAGES  (FB_STAGES),
        .RST_VAL (1'b1)
    ) u_fb_sync (
        .clk (clk),
        .rst (rst),
        .d   (rst_fb),
        .q   (fb_s)
    );

    assign t_hit    = (tcnt >= TO_LST);
    assign tcnt_inc = (tcnt == TO_MAX) ? tcnt : tcnt + 1'b1;

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        tcnt_nx  = tcnt;
        err_nx   = err;
        done_nx  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx = S_ASSERT;
                    pcnt_nx  = (pulse_len < MIN_V) ? MIN_V : pulse_len;
                    err_nx   = 1'b0;
                end
            end
            S_ASSERT: begin
                if (pcnt == ONE_V) begin
                    state_nx = S_WAIT_LO;
                    tcnt_nx  = '0;
                end else begin
                    pcnt_nx = pcnt - 1'b1;
                end
            end
            S_WAIT_LO: begin
                // A timeout still moves on so the controller is never stuck.
                if (!fb_s || t_hit) begin
                    state_nx = S_RELEASE_HI;
                    tcnt_nx  = '0;
                    if (fb_s) err_nx = 1'b1;
                end else begin
                    tcnt_nx = tcnt_inc;
                end
            end
            S_RELEASE_HI: begin
                if (fb_s || t_hit) begin
                    state_nx = S_COOL;
                    pcnt_nx  = COOL_V;
                    if (!fb_s) err_nx = 1'b1;
                end else begin
                    tcnt_nx = tcnt_inc;
                end
            end
            S_COOL: begin
                if (pcnt == ONE_V) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    pcnt_nx = pcnt - 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered: glitch-free drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pcnt      <= '0;
            tcnt      <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rst_n_out <= 1'b1;
        end else begin
            state     <= state_nx;
            pcnt      <= pcnt_nx;
            tcnt      <= tcnt_nx;
            err       <= err_nx;
            done      <= done_nx;
            busy      <= (state_nx != S_IDLE);
            rst_n_out <= !((state_nx == S_ASSERT) || (state_nx == S_WAIT_LO));
        end
    end

endmodule

// File: tb/tb_rst_req_gen.sv
// Directed bench for rst_req_gen with a delayed far-domain feedback model.
module tb_rst_req_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] pulse_len;
    logic       rst_fb;
    logic       rst_n_out, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Far-side synchronizer model: three flops on the opposite clock phase.
    logic [2:0] fb_sr = 3'b111;
    int         fb_mode = 0;
    logic [7:0] late_len;

    logic tr_rn [64];
    logic tr_bs [64];
    logic tr_dn [64];
    logic tr_er [64];
    logic req_v [64];
    logic rst_v [64];

    always #5 clk = ~clk;

    always @(negedge clk) fb_sr <= {fb_sr[1:0], rst_n_out};

    assign rst_fb = (fb_mode == 1) ? 1'b1 :
                    (fb_mode == 2) ? 1'b0 : fb_sr[2];

    rst_req_gen #(
        .CNT_W     (8),
        .MIN_PULSE (4),
        .FB_STAGES (2),
        .TIMEOUT   (20),
        .COOLDOWN  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .pulse_len (pulse_len),
        .rst_fb    (rst_fb),
        .rst_n_out (rst_n_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 64; k++) begin
            req_v[k] = 1'b0;
            rst_v[k] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] pl, input logic [7:0] later);
        pulse_len = pl;
        late_len  = later;
        req       = 1'b1;
    endtask

    // Sample k is the cycle after the k-th edge counted from acceptance.
    task automatic run(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            tr_rn[k]  = rst_n_out;
            tr_bs[k]  = busy;
            tr_dn[k]  = done;
            tr_er[k]  = err;
            req       = req_v[k];
            rst       = rst_v[k];
            pulse_len = late_len;
        end
        req = 1'b0;
        rst = 1'b0;
    endtask

    function automatic int cnt_low(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (tr_rn[k] === 1'b0) c++;
        return c;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int c = 0;
        for (int k = a; k <= b; k++) if (tr_dn[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_done(input int n);
        for (int k = 1; k <= n; k++) if (tr_dn[k] === 1'b1) return k;
        return 0;
    endfunction

    initial begin
        rst       = 1'b1;
        req       = 1'b0;
        pulse_len = 8'd0;
        late_len  = 8'd0;
        clear_stim();
        idle(2);
        chk("rst_rn", int'(rst_n_out), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        idle(3);

        // nominal, pulse_len changed after acceptance
        clear_stim();
        start(8'd6, 8'd20);
        run(25);
        chk("nom_rn_k1", int'(tr_rn[1]), 0);
        chk("nom_busy_k1", int'(tr_bs[1]), 1);
        chk("nom_low_cnt", cnt_low(1, 25), 7);
        chk("nom_rn_k7", int'(tr_rn[7]), 0);
        chk("nom_rn_k8", int'(tr_rn[8]), 1);
        chk("nom_done_at", first_done(25), 21);
        chk("nom_done_cnt", cnt_done(1, 25), 1);
        chk("nom_busy_k20", int'(tr_bs[20]), 1);
        chk("nom_busy_k21", int'(tr_bs[21]), 0);
        chk("nom_err", int'(tr_er[21]), 0);

        // clamp: 1 and 0 both become 4
        clear_stim();
        start(8'd1, 8'd1);
        run(22);
        chk("clamp1_low", cnt_low(1, 22), 5);
        chk("clamp1_rn_k6", int'(tr_rn[6]), 1);
        chk("clamp1_done", first_done(22), 19);
        clear_stim();
        start(8'd0, 8'd0);
        run(22);
        chk("clamp0_low", cnt_low(1, 22), 5);
        chk("clamp0_done", first_done(22), 19);

        // feedback stuck high
        fb_mode = 1;
        idle(4);
        clear_stim();
        start(8'd6, 8'd6);
        run(40);
        chk("st1_low", cnt_low(1, 40), 26);
        chk("st1_rn_k27", int'(tr_rn[27]), 1);
        chk("st1_err_k26", int'(tr_er[26]), 0);
        chk("st1_err_k27", int'(tr_er[27]), 1);
        chk("st1_done", first_done(40), 36);
        chk("st1_err_done", int'(tr_er[36]), 1);
        fb_mode = 0;
        idle(6);
        chk("st1_err_sticky", int'(err), 1);

        // feedback stuck low after release
        fb_mode = 2;
        idle(4);
        clear_stim();
        start(8'd6, 8'd6);
        run(40);
        chk("st0_err_clr", int'(tr_er[1]), 0);
        chk("st0_low", cnt_low(1, 40), 7);
        chk("st0_err_k27", int'(tr_er[27]), 0);
        chk("st0_err_k28", int'(tr_er[28]), 1);
        chk("st0_done", first_done(40), 36);
        fb_mode = 0;
        idle(6);

        // ignored requests, then req held through done
        clear_stim();
        req_v[3]  = 1'b1;
        req_v[14] = 1'b1;
        for (int k = 18; k <= 21; k++) req_v[k] = 1'b1;
        start(8'd6, 8'd6);
        run(45);
        chk("ign_done_at", first_done(45), 21);
        chk("ign_done_one", cnt_done(1, 41), 1);
        chk("hold_rn_k21", int'(tr_rn[21]), 1);
        chk("hold_busy_k21", int'(tr_bs[21]), 0);
        chk("hold_rn_k22", int'(tr_rn[22]), 0);
        chk("hold_busy_k22", int'(tr_bs[22]), 1);
        chk("hold_done_k42", int'(tr_dn[42]), 1);
        chk("hold_done_cnt", cnt_done(1, 45), 2);

        // reset in the 3rd assert cycle
        idle(4);
        clear_stim();
        rst_v[3] = 1'b1;
        start(8'd6, 8'd6);
        run(40);
        chk("mrst_rn_k3", int'(tr_rn[3]), 0);
        chk("mrst_rn_k4", int'(tr_rn[4]), 1);
        chk("mrst_busy_k4", int'(tr_bs[4]), 0);
        chk("mrst_low", cnt_low(1, 40), 3);
        chk("mrst_no_done", cnt_done(1, 40), 0);
        chk("mrst_busy_end", int'(tr_bs[40]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_req_gen.md
Name: rst_req_gen

Overview:
- Reset-request generator: the driving end of the reset synchronizer interface.
- On a request, it drives an active-low reset pulse of programmable width toward a downstream reset synchronizer, which may sit in another clock domain.
- It confirms the downstream domain entered and then left reset by watching that synchronizer's output, fed back here through an internal bit synchronizer.
- Reports completion or timeout to the system controller; sits in the controller's clock domain.

Parameters:
- CNT_W, 8: width of pulse_len and of the internal pulse counter.
- MIN_PULSE, 4: minimum assertion width in clk cycles; smaller requests are clamped up to this.
- FB_STAGES, 2: flop stages in the feedback synchronizer (minimum 2).
- TIMEOUT, 255: maximum cycles to wait for each feedback edge before flagging err.
- COOLDOWN, 8: idle cycles after confirmed release before done is pulsed.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- req, in, 1: reset request; sampled only in IDLE.
- pulse_len, in, CNT_W: assertion width in clk cycles; latched when req is accepted.
- rst_fb, in, 1: asynchronous feedback from the downstream synchronizer output (active-low).
- rst_n_out, out, 1: registered active-low reset drive to the downstream synchronizer.
- busy, out, 1: high from acceptance until return to IDLE.
- done, out, 1: one-cycle pulse when a sequence completes.
- err, out, 1: sticky timeout flag; cleared when the next req is accepted.

Behaviour:
- Reset (rst=1 at a clk edge): rst_n_out=1, busy=0, done=0, err=0, state=IDLE, counters=0, feedback sync flops=1.
- Reset mid-operation returns every output to its reset value at the next edge. It does not produce a done pulse. A shortened rst_n_out pulse is acceptable.
- FSM states: IDLE, ASSERT, WAIT_LO, RELEASE_HI, COOL.
- IDLE:
  - req=1 at edge N: latch len = max(pulse_len, MIN_PULSE), clear err, go to ASSERT.
  - rst_n_out=0 and busy=1 from cycle N+1.
  - req is also accepted in the same cycle that done is high.
- ASSERT: rst_n_out=0 for exactly len cycles, then WAIT_LO.
- WAIT_LO:
  - Hold rst_n_out=0 until fb_s (synchronized rst_fb) = 0.
  - If fb_s was already 0, exit after 1 cycle.
  - After TIMEOUT cycles in the state: set err=1 and proceed anyway.
  - Exit to RELEASE_HI.
- RELEASE_HI:
  - rst_n_out=1 from the first cycle in the state.
  - Wait for fb_s=1; TIMEOUT handling is the same as WAIT_LO.
  - Exit to COOL.
- COOL:
  - Wait COOLDOWN cycles with busy=1.
  - On exit: state=IDLE, busy=0, and done=1 in that same cycle only.
- req while busy=1 is ignored, not queued.
- pulse_len changes after acceptance have no effect.
- Timeout counter:
  - Width clog2(TIMEOUT+1).
  - Cleared on entry to WAIT_LO and RELEASE_HI.
  - Saturates; never wraps.
- Pulse counter: loads len, counts down, exits at 1.
  - pulse_len=0 clamps to MIN_PULSE; it is never treated as 256.
- Feedback latency: FB_STAGES cycles from an rst_fb change to fb_s.
- Glitch rule: rst_n_out is a flop output only, never combinational.

Decomposition:
- Package rst_req_pkg:
  - state encoding localparams;
  - helper function computing the timeout counter width.
- One sub-module, bit_sync:
  - parameterized FB_STAGES chain with reset value 1;
  - reused by other blocks for single-bit crossings.

Test Plan:
Benches run with MIN_PULSE=4, TIMEOUT=20, COOLDOWN=8, FB_STAGES=2, and a feedback model that copies rst_n_out with a 3-cycle delay unless overridden.
- Nominal: req at cycle 10, pulse_len=6.
  - rst_n_out low at cycles 11..16.
  - fb_s falls during ASSERT, so WAIT_LO lasts 1 cycle (cycle 17) and rst_n_out rises at cycle 18.
  - RELEASE_HI holds 5 cycles (18..22) until fb_s rises.
  - COOL lasts 8 cycles (23..30); done=1 and busy=0 at cycle 31, err=0.
- Clamp: pulse_len=1, then pulse_len=0.
  - Both give rst_n_out low for exactly 4 ASSERT cycles; the 1-cycle WAIT_LO makes the low pulse 5 cycles total.
- Feedback stuck at 1:
  - rst_n_out stays low for 6+20 cycles and err rises with the release.
  - done still pulses; err stays 1 until the next accepted req clears it.
- Feedback stuck at 0 after release:
  - RELEASE_HI times out after 20 cycles with err=1, then COOL runs and done pulses.
- req pulsed during ASSERT and COOL is ignored, giving exactly one done.
  - req held high through done starts a new sequence, with rst_n_out low on the next cycle.
- rst=1 for 1 cycle at the 3rd ASSERT cycle:
  - next edge gives rst_n_out=1, busy=0, done never asserts, state IDLE.
